// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and FSM states.
package mmio_uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-path load/store bus as seen by the UART window.
// The CPU side is the master; the peripheral is the slave.
interface mmio_uart_tx_if;

    logic        writeMem;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic        sel;
    logic [31:0] readData;

    modport master (
        output writeMem, addr, writeData,
        input  sel, readData
    );

    modport slave (
        input  writeMem, addr, writeData,
        output sel, readData
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; pushes when full
// and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset discards any buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, TXDATA/
// STATUS/DIV registers, TX FIFO and the serialising FSM.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'hFFFF_0000,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           busy
);

    logic [1:0]  off;
    logic        we;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] rdata;
    logic        ovf_q;
    logic [15:0] div_q;
    logic        unused_bits;

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [15:0] baudcnt_q, baudcnt_d;
    logic [15:0] reload_q, reload_d;
    logic        tx_q, tx_d;
    logic        bit_end;
    logic        load;

    assign bus.sel     = (bus.addr[31:4] == BASE[31:4]);
    assign off         = bus.addr[3:2];
    assign we          = bus.writeMem && bus.sel;
    assign push        = we && (off == OFF_TXDATA);
    assign unused_bits = ^{bus.addr[1:0], bus.writeData[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.writeData[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Read mux; anything outside the window or unmapped reads zero.
    always_comb begin
        rdata = '0;
        if (bus.sel) begin
            case (off)
                OFF_STATUS: begin
                    rdata[ST_OVF]   = ovf_q;
                    rdata[ST_BUSY]  = busy;
                    rdata[ST_FULL]  = fifo_full;
                    rdata[ST_EMPTY] = fifo_empty;
                end
                OFF_DIV: rdata[15:0] = div_q;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.readData = rdata;

    // Control registers: sticky overflow flag and baud divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            div_q <= DIV_RESET;
        end else if (we) begin
            if (off == OFF_STATUS)
                ovf_q <= 1'b0;
            else if (off == OFF_TXDATA && fifo_full)
                ovf_q <= 1'b1;
            if (off == OFF_DIV)
                div_q <= bus.writeData[15:0];
        end
    end

    // Serialiser state; tx returns high immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            baudcnt_q <= '0;
            reload_q  <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            baudcnt_q <= baudcnt_d;
            reload_q  <= reload_d;
            tx_q      <= tx_d;
        end
    end

    assign bit_end = (baudcnt_q == reload_q);

    // Frame sequencing; each bit reloads its length from DIV.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        baudcnt_d = baudcnt_q;
        reload_d  = reload_q;
        tx_d      = tx_q;
        load      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                load = !fifo_empty;
            end
            S_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    state_d   = S_DATA;
                    baudcnt_d = '0;
                    reload_d  = div_q;
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baudcnt_d = '0;
                    reload_d  = div_q;
                    if (bitcnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baudcnt_d = '0;
                    load      = !fifo_empty;
                    if (fifo_empty) state_d = S_IDLE;
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            shift_d   = fifo_dout;
            tx_d      = 1'b0;
            state_d   = S_START;
            bitcnt_d  = '0;
            baudcnt_d = '0;
            reload_d  = div_q;
        end
    end

    assign pop  = load;
    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing,
// back-to-back frames, overflow, DIV change and async reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk;
    logic rst;
    logic tx;
    logic busy;
    logic [31:0] d;
    int total = 0;
    int bad = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE      (BASE),
        .DEPTH     (8),
        .DIV_RESET (16'd433)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.addr      = a;
        bus.writeData = wd;
        bus.writeMem  = 1'b1;
        @(posedge clk);
        #1;
        bus.writeMem  = 1'b0;
        bus.addr      = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        @(negedge clk);
        bus.addr = a;
        #1;
        rd = bus.readData;
    endtask

    // Expected line level per cycle; bits before index sw last bt
    // cycles, later bits bt2 cycles.
    task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1,
                                input int n, input int bt, input int bt2,
                                input int sw);
        logic [7:0] b;
        logic e;
        int len;
        int j;
        j = 0;
        for (int f = 0; f < n; f++) begin
            b = (f == 0) ? b0 : b1;
            for (int k = 0; k < 10; k++) begin
                e = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
                len = (j < sw) ? bt : bt2;
                for (int c = 0; c < len; c++) begin
                    @(posedge clk);
                    #1;
                    chk("txbit", {31'b0, tx}, {31'b0, e});
                end
                j++;
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.writeMem  = 1'b0;
        bus.addr      = 32'h0;
        bus.writeData = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        bus_read(BASE + 32'h4, d);
        chk("rst_status", d, 32'h1);
        bus_read(BASE + 32'h8, d);
        chk("rst_div", d, 32'd433);
        chk("sel_in", {31'b0, bus.sel}, 32'h1);
        bus_read(BASE + 32'hC, d);
        chk("rsvd_rd", d, 32'h0);
        bus_read(BASE, d);
        chk("txdata_rd", d, 32'h0);

        // 0x55 at DIV=3
        bus_write(BASE + 32'h8, 32'h3);
        bus_read(BASE + 32'h8, d);
        chk("div3", d, 32'h3);
        bus_write(BASE, 32'h55);
        chk("t1_busy", {31'b0, busy}, 32'h1);
        check_frames(8'h55, 8'h00, 1, 4, 4, 99);
        @(posedge clk);
        #1;
        chk("t1_busy_end", {31'b0, busy}, 32'h0);
        chk("t1_tx_end", {31'b0, tx}, 32'h1);

        // fill, overflow, clear at DIV=0
        bus_write(BASE + 32'h8, 32'h0);
        for (int i = 0; i < 9; i++)
            bus_write(BASE, 32'h10 + i);
        bus_read(BASE + 32'h4, d);
        chk("t2_full", d, 32'h6);
        bus_write(BASE, 32'hEE);
        bus_read(BASE + 32'h4, d);
        chk("t2_ovf", d, 32'hE);
        bus_write(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, d);
        chk("t2_ovf_clr", {31'b0, d[3]}, 32'h0);
        wait_idle(400);
        bus_read(BASE + 32'h4, d);
        chk("t2_drained", d, 32'h1);

        // back-to-back frames, 1 cycle/bit
        bus_write(BASE, 32'h00);
        fork
            check_frames(8'h00, 8'hFF, 2, 1, 1, 99);
            bus_write(BASE, 32'hFF);
        join
        @(posedge clk);
        #1;
        chk("t3_busy_end", {31'b0, busy}, 32'h0);

        // outside the window
        @(negedge clk);
        bus.addr = BASE + 32'h10;
        #1;
        chk("t4_sel_hi", {31'b0, bus.sel}, 32'h0);
        chk("t4_rd_hi", bus.readData, 32'h0);
        bus_write(BASE + 32'h10, 32'hA5);
        bus_write(32'h0, 32'hA5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t4_tx", {31'b0, tx}, 32'h1);
        end
        bus_read(32'h0, d);
        chk("t4_rd_zero", d, 32'h0);
        chk("t4_sel_zero", {31'b0, bus.sel}, 32'h0);
        bus_read(BASE + 32'h4, d);
        chk("t4_status", d, 32'h1);

        // DIV change during data bit 3
        bus_write(BASE + 32'h8, 32'h3);
        bus_write(BASE, 32'hA3);
        fork
            check_frames(8'hA3, 8'h00, 1, 4, 8, 5);
            begin
                repeat (17) @(posedge clk);
                bus_write(BASE + 32'h8, 32'h7);
            end
        join
        @(posedge clk);
        #1;
        chk("t5_busy_end", {31'b0, busy}, 32'h0);
        bus_read(BASE + 32'h8, d);
        chk("t5_div", d, 32'h7);

        // async reset mid data bit
        bus_write(BASE + 32'h8, 32'h3);
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'h5A);
        bus_write(BASE, 32'h5B);
        repeat (10) @(posedge clk);
        #2;
        chk("t6_tx_low", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_tx_async", {31'b0, tx}, 32'h1);
        chk("t6_busy_rst", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(BASE + 32'h4, d);
        chk("t6_status", d, 32'h1);
        bus_read(BASE + 32'h8, d);
        chk("t6_div", d, 32'd433);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_tx_idle", {31'b0, tx}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
